step_sequencer: RTL
===================

Name: step_sequencer

Overview:
- Controller that runs a fixed number of test steps against a worker block, one after another.
- For each step it issues a one-cycle start pulse, waits for a done/ok handshake under a per-step timeout, then either advances to the next step or stops with a failure.
- Sits between a self-checking testbench top and the block under test, replacing ad hoc cycle-compare sequencing.
- Exposes sticky finished/failed flags and a saturating cycle counter.

Parameters:
- NSTEPS, 4, number of steps to run; legal range 1..255.
- TIMEOUT, 15, maximum WAIT cycles allowed per step; legal range 1..255.
- CW, 8, width of the cycle counter.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- enable  input  1  starts the sequence; sampled only in IDLE
- step_start  output  1  one-cycle start pulse to the worker
- step_idx  output  8  index of the current step, 0..NSTEPS-1
- step_done  input  1  worker completed the current step
- step_ok  input  1  worker result; valid only when step_done=1
- busy  output  1  high in ISSUE and WAIT
- finished  output  1  sticky: all steps passed
- failed  output  1  sticky: a step failed or timed out
- fail_step  output  8  index of the failing step; 0 unless failed=1
- cyc  output  CW  cycles since reset release; saturates at all-ones

Behaviour:
- All outputs are registered.
- While rst=1: state=IDLE, step_start=0, step_idx=0, busy=0, finished=0, failed=0, fail_step=0, cyc=0, wait timer=0.
- Reset takes effect immediately, at any point, including mid-step. A step_start pulse in flight is cleared asynchronously.
- cyc increments on every clk edge with rst=0. It holds at 2^CW-1 and never wraps.
- FSM states: IDLE, ISSUE, WAIT, DONE, FAIL.
- IDLE, enable=1 at edge k: go to ISSUE. step_start=1 and busy=1 during cycle k..k+1. enable=0: stay in IDLE.
- ISSUE: lasts exactly one cycle, then WAIT. step_start returns to 0. Timer is cleared to 0.
  - step_done is ignored during ISSUE, i.e. in the same cycle as step_start.
- WAIT, each edge:
  - step_done=1 and step_ok=1 and step_idx<NSTEPS-1: step_idx+1, go to ISSUE (next start pulse follows immediately).
  - step_done=1 and step_ok=1 and step_idx=NSTEPS-1: go to DONE. finished=1, busy=0. step_idx holds NSTEPS-1.
  - step_done=1 and step_ok=0: go to FAIL. failed=1, fail_step=step_idx, busy=0.
  - step_done=0 and timer=TIMEOUT-1: go to FAIL, same outputs as above (timeout).
  - step_done=0 otherwise: timer+1, stay in WAIT.
- step_done is therefore accepted on any of WAIT cycles 0..TIMEOUT-1.
- Simultaneous step_done with the timeout cycle: step_done wins, and step_ok decides the outcome.
- DONE and FAIL are terminal until rst. enable, step_done and step_ok are ignored there.
- finished and failed are never both 1.
- enable is don't-care after leaving IDLE; deasserting it mid-run does not abort.
- Per-step latency: start pulse to next start pulse = (WAIT cycles until done) + 2 cycles.
- With NSTEPS=1, the first accepted ok goes directly to DONE.

Test Plan:
- Default params, worker asserts done+ok 3 cycles after each start: exactly 4 start pulses 5 cycles apart. step_idx goes 0,1,2,3; finished=1 one edge after the last done; failed=0.
- Step 2 returns done with ok=0: failed=1, fail_step=2, finished=0, no further start pulses. Later enable/done toggling changes nothing.
- Worker never answers step 0 (TIMEOUT=15): failed=1, fail_step=0 exactly 16 edges after the start pulse edge (1 ISSUE + 15 WAIT).
- done+ok on the final WAIT cycle (timer=14): step is accepted and the sequence advances, no timeout. done+ok held in the ISSUE cycle only: it is ignored and the step times out.
- Assert rst asynchronously mid-WAIT of step 1: step_start, busy, step_idx and cyc go to 0 before the next clk edge. After release with enable=1, the sequence restarts at step 0.
- CW=4, enable=0 for 20 cycles: cyc counts 0..15 and stays at 15; busy=0; no start pulse.

Source files
------------

// File: rtl/step_sequencer.sv
// ---------------------------------------------------------------------------
// step_sequencer
//
// Purpose:
//   Runs NSTEPS test steps against a worker block, strictly one after another.
//   For every step a one-cycle start pulse is issued, then the controller
//   waits for the worker's done/ok handshake under a per-step timeout. A good
//   result advances to the next step (or finishes after the last one); a bad
//   result or a timeout stops the sequence with a sticky failure. A saturating
//   cycle counter runs alongside for the benefit of the surrounding test top.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous, active-high reset
//   enable     in   starts the sequence; only looked at while idle
//   step_start out  one-cycle start pulse to the worker
//   step_idx   out  index of the step currently being run (0..NSTEPS-1)
//   step_done  in   worker has completed the current step
//   step_ok    in   worker result, meaningful only together with step_done
//   busy       out  a step is being issued or awaited
//   finished   out  sticky: every step passed
//   failed     out  sticky: a step reported a failure or timed out
//   fail_step  out  index of the failing step, 0 unless failed is set
//   cyc        out  cycles since reset release, saturating at all-ones
//
// Every output comes straight from a flop.
// ---------------------------------------------------------------------------
module step_sequencer #(
    parameter int NSTEPS  = 4,
    parameter int TIMEOUT = 15,
    parameter int CW      = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    output logic          step_start,
    output logic [7:0]    step_idx,
    input  logic          step_done,
    input  logic          step_ok,
    output logic          busy,
    output logic          finished,
    output logic          failed,
    output logic [7:0]    fail_step,
    output logic [CW-1:0] cyc
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_DONE  = 3'd3,
        S_FAIL  = 3'd4
    } state_t;

    // Index of the final step and the last WAIT cycle a step is allowed.
    localparam logic [7:0]    LAST_IDX   = 8'(NSTEPS - 1);
    localparam logic [7:0]    TIMER_LAST = 8'(TIMEOUT - 1);
    localparam logic [CW-1:0] CYC_MAX    = '1;
    localparam logic [CW-1:0] CYC_ONE    = {{(CW-1){1'b0}}, 1'b1};

    state_t        state_q,      state_d;
    logic [7:0]    step_idx_q,   step_idx_d;
    logic [7:0]    timer_q,      timer_d;
    logic [7:0]    fail_step_q,  fail_step_d;
    logic          step_start_q, step_start_d;
    logic          busy_q,       busy_d;
    logic          finished_q,   finished_d;
    logic          failed_q,     failed_d;
    logic [CW-1:0] cyc_q,        cyc_d;

    // State register. The reset is asynchronous so that a start pulse that
    // is already on the wire is withdrawn at once, not at the next edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            step_idx_q   <= 8'd0;
            timer_q      <= 8'd0;
            fail_step_q  <= 8'd0;
            step_start_q <= 1'b0;
            busy_q       <= 1'b0;
            finished_q   <= 1'b0;
            failed_q     <= 1'b0;
            cyc_q        <= '0;
        end else begin
            state_q      <= state_d;
            step_idx_q   <= step_idx_d;
            timer_q      <= timer_d;
            fail_step_q  <= fail_step_d;
            step_start_q <= step_start_d;
            busy_q       <= busy_d;
            finished_q   <= finished_d;
            failed_q     <= failed_d;
            cyc_q        <= cyc_d;
        end
    end

    // Next-state logic, together with the step index, the WAIT timer and the
    // captured failing index, since all of them only move on FSM transitions.
    // In WAIT a done handshake is always examined before the timeout, so a
    // done arriving on the very last allowed cycle still counts. Nothing is
    // sampled during ISSUE, which is how a done coinciding with the start
    // pulse gets ignored.
    always_comb begin
        state_d     = state_q;
        step_idx_d  = step_idx_q;
        timer_d     = timer_q;
        fail_step_d = fail_step_q;

        unique case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d = S_ISSUE;
                end
            end

            S_ISSUE: begin
                state_d = S_WAIT;
                timer_d = 8'd0;
            end

            S_WAIT: begin
                if (step_done) begin
                    if (step_ok) begin
                        if (step_idx_q == LAST_IDX) begin
                            state_d = S_DONE;
                        end else begin
                            state_d    = S_ISSUE;
                            step_idx_d = step_idx_q + 8'd1;
                        end
                    end else begin
                        state_d     = S_FAIL;
                        fail_step_d = step_idx_q;
                    end
                end else if (timer_q == TIMER_LAST) begin
                    state_d     = S_FAIL;
                    fail_step_d = step_idx_q;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end

            S_DONE, S_FAIL: begin
                state_d = state_q;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output logic. Outputs are decoded from the state being entered so that
    // they can be registered and still line up with that state: the start
    // pulse is high for exactly the ISSUE cycle, and the sticky flags rise on
    // the same edge that enters DONE or FAIL.
    always_comb begin
        step_start_d = 1'b0;
        busy_d       = 1'b0;
        finished_d   = 1'b0;
        failed_d     = 1'b0;

        unique case (state_d)
            S_ISSUE: begin
                step_start_d = 1'b1;
                busy_d       = 1'b1;
            end
            S_WAIT: begin
                busy_d = 1'b1;
            end
            S_DONE: begin
                finished_d = 1'b1;
            end
            S_FAIL: begin
                failed_d = 1'b1;
            end
            default: begin
                step_start_d = 1'b0;
            end
        endcase

        // Free-running cycle counter that sticks at its maximum.
        if (cyc_q == CYC_MAX) begin
            cyc_d = cyc_q;
        end else begin
            cyc_d = cyc_q + CYC_ONE;
        end
    end

    assign step_start = step_start_q;
    assign step_idx   = step_idx_q;
    assign busy       = busy_q;
    assign finished   = finished_q;
    assign failed     = failed_q;
    assign fail_step  = fail_step_q;
    assign cyc        = cyc_q;

endmodule
